// File: rtl/spi_capture_pkg.sv
// rtl/spi_capture_pkg.sv - register map, field positions and captured-entry type for spi_capture_avalon_fifo
package spi_capture_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_PEEK    = 2'd3;

    localparam int DATA_VALID_BIT  = 31;
    localparam int DATA_TAG_BIT    = 16;

    localparam int STAT_LEVEL_LSB  = 0;
    localparam int STAT_LEVEL_W    = 8;
    localparam int STAT_EMPTY_BIT  = 8;
    localparam int STAT_FULL_BIT   = 9;
    localparam int STAT_OVF_BIT    = 10;
    localparam int STAT_DROP_LSB   = 16;

    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_THR_LSB    = 8;
    localparam int THR_W           = 8;

    localparam int PEEK_FRAME_LSB  = 16;

    localparam int DROP_CNT_W      = 16;
    localparam int FRAME_CNT_W     = 16;
    localparam int MAX_DATA_W      = 16;

    // Words are stored zero-extended to the widest legal DATA_W.
    typedef struct packed {
        logic                  tag;
        logic [MAX_DATA_W-1:0] word;
    } cap_entry_t;

endpackage

// File: rtl/spi_capture_ring.sv
// rtl/spi_capture_ring.sv - synchronous FIFO storage and pointers for captured entries
module spi_capture_ring
    import spi_capture_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  cap_entry_t             i_wdata,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output cap_entry_t             o_rdata,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    cap_entry_t     r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_capture_avalon_fifo.sv
// rtl/spi_capture_avalon_fifo.sv - SPI word capture FIFO behind a 4-word Avalon-MM slave (option: SPI_CAPTURE_IRQ_EN)
module spi_capture_avalon_fifo
    import spi_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_InputBuffer,
    input  logic              io_BufferChanged,
    input  logic              io_FrameStart,
    input  logic [1:0]        io_Avalon_address,
    input  logic              io_Avalon_read,
    input  logic              io_Avalon_write,
    input  logic [31:0]       io_Avalon_writedata,
    output logic [31:0]       io_Avalon_readdata,
    output logic              io_Irq
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                   r_bc_prev;
    logic                   r_tag_pending;
    logic                   r_overflow;
    logic [DROP_CNT_W-1:0]  r_drop_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [MAX_DATA_W-1:0]  r_last_word;
    logic [31:0]            r_readdata;

    logic                   w_capture;
    logic                   w_rd_data;
    logic                   w_wr_ctrl;
    logic                   w_flush;
    logic                   w_clear;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [LVL_W-1:0]       w_level;
    logic [MAX_DATA_W-1:0]  w_word_ext;
    cap_entry_t             w_new_entry;
    cap_entry_t             w_head;
    logic [31:0]            w_rd_next;

    assign w_capture  = io_BufferChanged & ~r_bc_prev;
    assign w_rd_data  = io_Avalon_read  & (io_Avalon_address == ADDR_DATA);
    assign w_wr_ctrl  = io_Avalon_write & (io_Avalon_address == ADDR_CONTROL);
    assign w_flush    = w_wr_ctrl & io_Avalon_writedata[CTRL_FLUSH_BIT];
    assign w_clear    = w_wr_ctrl & io_Avalon_writedata[CTRL_CLEAR_BIT];

    // A pop on a full FIFO frees the slot the colliding capture needs.
    assign w_pop      = w_rd_data & ~w_empty;
    assign w_push     = w_capture & ~w_flush & (~w_full | w_pop);
    assign w_drop     = w_capture & ~w_flush & w_full & ~w_pop;

    assign w_word_ext  = MAX_DATA_W'(io_InputBuffer);
    assign w_new_entry = '{tag: (r_tag_pending | io_FrameStart), word: w_word_ext};

    spi_capture_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_wdata (w_new_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef SPI_CAPTURE_IRQ_EN
    logic [THR_W-1:0] r_threshold;
    logic             r_irq;
    logic             w_unused_wdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_threshold <= THR_W'(DEPTH / 2);
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_threshold <= io_Avalon_writedata[CTRL_THR_LSB +: THR_W];
            end
            r_irq <= (THR_W'(w_level) >= r_threshold);
        end
    end

    assign io_Irq         = r_irq;
    assign w_unused_wdata = ^{io_Avalon_writedata[31:16], io_Avalon_writedata[7:2]};
`else
    logic w_unused_wdata;

    assign io_Irq         = 1'b0;
    assign w_unused_wdata = ^io_Avalon_writedata[31:2];
`endif

    always_comb begin
        w_rd_next = '0;
        case (io_Avalon_address)
            ADDR_DATA: begin
                if (!w_empty) begin
                    w_rd_next[DATA_VALID_BIT]   = 1'b1;
                    w_rd_next[DATA_TAG_BIT]     = w_head.tag;
                    w_rd_next[MAX_DATA_W-1:0]   = w_head.word;
                end
            end
            ADDR_STATUS: begin
                w_rd_next[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(w_level);
                w_rd_next[STAT_EMPTY_BIT]                 = w_empty;
                w_rd_next[STAT_FULL_BIT]                  = w_full;
                w_rd_next[STAT_OVF_BIT]                   = r_overflow;
                w_rd_next[STAT_DROP_LSB +: DROP_CNT_W]    = r_drop_cnt;
            end
            ADDR_CONTROL: begin
`ifdef SPI_CAPTURE_IRQ_EN
                w_rd_next[CTRL_THR_LSB +: THR_W] = r_threshold;
`else
                w_rd_next = '0;
`endif
            end
            ADDR_PEEK: begin
                w_rd_next[MAX_DATA_W-1:0]                  = r_last_word;
                w_rd_next[PEEK_FRAME_LSB +: FRAME_CNT_W]   = r_frame_cnt;
            end
            default: w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bc_prev     <= 1'b0;
            r_tag_pending <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= '0;
            r_frame_cnt   <= '0;
            r_last_word   <= '0;
            r_readdata    <= '0;
        end else begin
            r_bc_prev <= io_BufferChanged;

            // A tag is consumed only by a word that actually enters the FIFO.
            if (w_flush) begin
                r_tag_pending <= 1'b0;
            end else if (w_push) begin
                r_tag_pending <= 1'b0;
            end else if (io_FrameStart) begin
                r_tag_pending <= 1'b1;
            end

            if (io_FrameStart) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (w_capture) begin
                r_last_word <= w_word_ext;
            end

            if (w_clear) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end

            if (io_Avalon_read) begin
                r_readdata <= w_rd_next;
            end
        end
    end

    assign io_Avalon_readdata = r_readdata;

endmodule
